u_bam_mac8: RTL and testbench

//  Streaming multiply-accumulate stage built around an 8x8 broken-array approximate multiplier (BAM).

---
 rtl/bam_mac_pkg.sv | 19 +
 rtl/bam_pp_mult8.sv | 36 +++
 rtl/u_bam_mac8.sv | 180 ++++++++++++++++++
 tb/tb_u_bam_mac8.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bam_mac_pkg.sv
// -----------------------------------------------------------------------------
// bam_mac_pkg
//   Shared constants and helpers for the broken-array MAC stage.
//   PROD_W    : width of the 8x8 product (16 bits, unsigned)
//   OP_W      : operand width (8 bits, unsigned)
//   bam_kept  : returns 1 when partial product a[i]&b[j] survives the
//               horizontal (i+j >= hbl) and vertical (j >= vbl) breaks
// -----------------------------------------------------------------------------
package bam_mac_pkg;

  localparam int PROD_W = 16;
  localparam int OP_W   = 8;

  function automatic logic bam_kept(input int i, input int j,
                                    input int hbl, input int vbl);
    return ((i + j) >= hbl) && (j >= vbl);
  endfunction

endpackage

// File: rtl/bam_pp_mult8.sv
// -----------------------------------------------------------------------------
// bam_pp_mult8
//   Combinational 8x8 unsigned broken-array approximate multiplier.
//   Partial products below the horizontal break (i+j < HBL) or left of the
//   vertical break (j < VBL) are dropped; the rest are summed exactly with
//   no compensation term. HBL=0, VBL=0 gives the exact product.
//   Ports:
//     a  in  8   multiplicand
//     b  in  8   multiplier
//     p  out 16  approximate product
// -----------------------------------------------------------------------------
module bam_pp_mult8
  import bam_mac_pkg::*;
#(
  parameter int HBL = 7,
  parameter int VBL = 7
)(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  // Break tests depend only on parameters, so the kept/dropped pattern is
  // fixed at elaboration and the loop collapses to a pruned adder array.
  always_comb begin
    p = '0;
    for (int j = 0; j < OP_W; j++) begin
      for (int i = 0; i < OP_W; i++) begin
        if (bam_kept(i, j, HBL, VBL)) begin
          p = p + (PROD_W'(a[i] & b[j]) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/u_bam_mac8.sv
// -----------------------------------------------------------------------------
// u_bam_mac8
//   Streaming multiply-accumulate stage around an 8x8 broken-array
//   approximate multiplier. Operand beats arrive over valid/ready, the
//   approximate product of each beat is accumulated over a packet ended by
//   in_last, and one registered sum per packet is offered downstream.
//
//   Pipeline: S1 operand register -> S2 product register -> accumulator and
//   output register. A last beat accepted on edge T shows out_valid after
//   edge T+2. One beat per cycle while downstream keeps up.
//
//   Configuration macro:
//     BAM_MAC_SAT_EN  defined : accumulator clamps at 2^ACC_W-1 on carry-out
//                     undefined: accumulator wraps modulo 2^ACC_W
//     out_ovf reports the carry-out in both builds.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset
//     in_a       in   8      multiplicand (unsigned)
//     in_b       in   8      multiplier (unsigned)
//     in_last    in   1      final beat of packet
//     in_valid   in   1      operand beat valid
//     in_ready   out  1      beat accepted when in_valid & in_ready
//     out_sum    out  ACC_W  packet sum of approximate products
//     out_count  out  CNT_W  beats in packet, saturating at all-ones
//     out_ovf    out  1      accumulator carried out during the packet
//     out_valid  out  1      result valid, held until out_ready
//     out_ready  in   1      downstream accepts result
// -----------------------------------------------------------------------------
module u_bam_mac8
  import bam_mac_pkg::*;
#(
  parameter int HBL   = 7,
  parameter int VBL   = 7,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  // Saturating beat counter increment.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Reduce the ACC_W+1 bit raw sum back to the accumulator width.
  function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] s);
`ifdef BAM_MAC_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  logic              adv;

  logic [OP_W-1:0]   a_p1;
  logic [OP_W-1:0]   b_p1;
  logic              last_p1;
  logic              vld_p1;

  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] prod_p2;
  logic              last_p2;
  logic              vld_p2;

  logic              first;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic              step;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    sum_ext;
  logic              carry;
  logic [ACC_W-1:0]  acc_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              ovf_n;

  // The whole pipeline moves together; it only stalls when a result is
  // parked at the output and downstream is not taking it.
  assign adv      = !(out_valid && !out_ready);
  // During reset the output register is being cleared, so advertise ready.
  assign in_ready = rst || adv;

  // ---- S1: operand register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_p1    <= in_a;
      b_p1    <= in_b;
      last_p1 <= in_last;
    end
  end

  bam_pp_mult8 #(
    .HBL (HBL),
    .VBL (VBL)
  ) u_mult (
    .a (a_p1),
    .b (b_p1),
    .p (prod_c)
  );

  // ---- S2: product register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      prod_p2 <= prod_c;
      last_p2 <= last_p1;
    end
  end

  // ---- ACC: accumulate and output register ----
  always_comb begin
    step     = vld_p2 && adv;
    acc_base = first ? '0 : acc;
    sum_ext  = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_p2};
    carry    = sum_ext[ACC_W];
    acc_n    = acc_limit(sum_ext);
    cnt_n    = first ? CNT_W'(1) : sat_cnt(cnt);
    ovf_n    = (!first && ovf) || carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first     <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (step) begin
        acc   <= acc_n;
        cnt   <= cnt_n;
        ovf   <= ovf_n;
        first <= last_p2;
      end
      // A new result may replace one being handed off on the same edge.
      if (step && last_p2) begin
        out_sum   <= acc_n;
        out_count <= cnt_n;
        out_ovf   <= ovf_n;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_u_bam_mac8.sv
module tb_u_bam_mac8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_a, in_b;
  logic        in_last, in_valid, out_ready;

  logic        rdy_d, rdy_x, rdy_w;
  logic [23:0] sum_d, sum_x;
  logic [15:0] sum_w;
  logic [7:0]  cnt_d, cnt_x, cnt_w;
  logic        ovf_d, ovf_x, ovf_w;
  logic        vld_d, vld_x, vld_w;

  int checks   = 0;
  int failures = 0;

`ifdef BAM_MAC_SAT_EN
  localparam logic [15:0] W16_EXP = 16'hFFFF;
`else
  localparam logic [15:0] W16_EXP = 16'h7E80;
`endif

  always #5 clk = ~clk;

  u_bam_mac8 dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_d), .out_sum(sum_d), .out_count(cnt_d),
    .out_ovf(ovf_d), .out_valid(vld_d), .out_ready(out_ready)
  );

  u_bam_mac8 #(.HBL(0), .VBL(0)) dut_x (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_x), .out_sum(sum_x), .out_count(cnt_x),
    .out_ovf(ovf_x), .out_valid(vld_x), .out_ready(out_ready)
  );

  u_bam_mac8 #(.ACC_W(16)) dut_w (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(rdy_w), .out_sum(sum_w), .out_count(cnt_w),
    .out_ovf(ovf_w), .out_valid(vld_w), .out_ready(out_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (rdy_d) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL send_beat_timeout got=no_accept exp=accept");
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", vld_d); end
    checks++; if (sum_d !== 24'h0) begin failures++; $display("FAIL rst_sum got=%h exp=0", sum_d); end
    checks++; if (cnt_d !== 8'h0) begin failures++; $display("FAIL rst_count got=%h exp=0", cnt_d); end
    checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf_d); end
    checks++; if ({rdy_d, rdy_x, rdy_w} !== 3'b111) begin failures++; $display("FAIL rst_in_ready got=%b exp=111", {rdy_d, rdy_x, rdy_w}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    send_beat(8'hFF, 8'h80, 1'b1);
    idle();
    checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL t1_early_valid_e0 got=%b exp=0", vld_d); end
    @(posedge clk); #1;
    checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL t1_early_valid_e1 got=%b exp=0", vld_d); end
    @(posedge clk); #1;
    checks++; if (vld_d !== 1'b1) begin failures++; $display("FAIL t1_valid got=%b exp=1", vld_d); end
    checks++; if (sum_d !== 24'h007F80) begin failures++; $display("FAIL t1_sum got=%h exp=007f80", sum_d); end
    checks++; if (cnt_d !== 8'd1) begin failures++; $display("FAIL t1_count got=%0d exp=1", cnt_d); end
    checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL t1_ovf got=%b exp=0", ovf_d); end
    checks++; if (sum_x !== 24'd32640) begin failures++; $display("FAIL t1_exact_sum got=%0d exp=32640", sum_x); end
    @(posedge clk); #1;
    checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL t1_valid_drop got=%b exp=0", vld_d); end
  endtask

  task automatic test_break_and_packet();
    send_beat(8'hFF, 8'h7F, 1'b1);
    idle();
    repeat (2) @(posedge clk); #1;
    checks++; if (vld_d !== 1'b1 || sum_d !== 24'h0) begin failures++; $display("FAIL t2_dropped_sum got=%h exp=0", sum_d); end
    checks++; if (sum_x !== 24'd32385) begin failures++; $display("FAIL t2_exact_7f got=%0d exp=32385", sum_x); end
    @(posedge clk); #1;
    send_beat(8'hFF, 8'h80, 1'b0);
    send_beat(8'hFF, 8'h80, 1'b0);
    send_beat(8'hFF, 8'h80, 1'b1);
    idle();
    repeat (2) @(posedge clk); #1;
    checks++; if (sum_d !== 24'h017E80) begin failures++; $display("FAIL t2_pkt_sum got=%h exp=017e80", sum_d); end
    checks++; if (cnt_d !== 8'd3) begin failures++; $display("FAIL t2_pkt_count got=%0d exp=3", cnt_d); end
    checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL t2_pkt_ovf got=%b exp=0", ovf_d); end
    checks++; if (sum_w !== W16_EXP) begin failures++; $display("FAIL t4_w16_sum got=%h exp=%h", sum_w, W16_EXP); end
    checks++; if (ovf_w !== 1'b1) begin failures++; $display("FAIL t4_w16_ovf got=%b exp=1", ovf_w); end
    checks++; if (cnt_w !== 8'd3) begin failures++; $display("FAIL t4_w16_count got=%0d exp=3", cnt_w); end
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    send_beat(8'd200, 8'd100, 1'b0);
    send_beat(8'd3, 8'd5, 1'b1);
    idle();
    repeat (2) @(posedge clk); #1;
    checks++; if (sum_x !== 24'd20015) begin failures++; $display("FAIL t3_exact_sum got=%0d exp=20015", sum_x); end
    checks++; if (cnt_x !== 8'd2) begin failures++; $display("FAIL t3_exact_count got=%0d exp=2", cnt_x); end
    checks++; if (ovf_x !== 1'b0) begin failures++; $display("FAIL t3_exact_ovf got=%b exp=0", ovf_x); end
    checks++; if (sum_d !== 24'h0) begin failures++; $display("FAIL t3_bam_sum got=%h exp=0", sum_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_sums [3];
    exp_sums[0] = 24'h80; exp_sums[1] = 24'h100; exp_sums[2] = 24'h200;
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b1;
    in_a = 8'hFF; in_b = 8'h80; @(posedge clk); #1;
    in_a = 8'h01;               @(posedge clk); #1;
    in_a = 8'h02;               @(posedge clk); #1;
    in_a = 8'h04;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rdy_d !== 1'b0) begin failures++; $display("FAIL t5_stall_ready c=%0d got=%b exp=0", c, rdy_d); end
      checks++; if (vld_d !== 1'b1 || sum_d !== 24'h7F80 || cnt_d !== 8'd1) begin failures++; $display("FAIL t5_stall_hold c=%0d got=%b/%h/%0d exp=1/007f80/1", c, vld_d, sum_d, cnt_d); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle();
    for (int r = 0; r < 3; r++) begin
      checks++; if (vld_d !== 1'b1 || sum_d !== exp_sums[r] || sum_x !== exp_sums[r]) begin failures++; $display("FAIL t5_drain r=%0d got=%b/%h/%h exp=1/%h", r, vld_d, sum_d, sum_x, exp_sums[r]); end
      @(posedge clk); #1;
    end
    checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL t5_drain_end got=%b exp=0", vld_d); end
  endtask

  task automatic test_reset_mid_packet();
    send_beat(8'hFF, 8'h80, 1'b0);
    send_beat(8'hFF, 8'h80, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (vld_d !== 1'b0 || rdy_d !== 1'b1) begin failures++; $display("FAIL t6_in_reset got=%b/%b exp=0/1", vld_d, rdy_d); end
    rst = 1'b0;
    send_beat(8'hFF, 8'h80, 1'b1);
    idle();
    repeat (2) @(posedge clk); #1;
    checks++; if (vld_d !== 1'b1 || sum_d !== 24'h7F80) begin failures++; $display("FAIL t6_sum got=%b/%h exp=1/007f80", vld_d, sum_d); end
    checks++; if (cnt_d !== 8'd1 || ovf_d !== 1'b0) begin failures++; $display("FAIL t6_count got=%0d/%b exp=1/0", cnt_d, ovf_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_count_sat();
    for (int n = 0; n < 300; n++) send_beat(8'h01, 8'h80, (n == 299));
    idle();
    repeat (2) @(posedge clk); #1;
    checks++; if (cnt_d !== 8'hFF) begin failures++; $display("FAIL t7_count_sat got=%0d exp=255", cnt_d); end
    checks++; if (sum_d !== 24'd38400 || sum_w !== 16'd38400) begin failures++; $display("FAIL t7_sum got=%0d/%0d exp=38400", sum_d, sum_w); end
    checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL t7_w16_ovf got=%b exp=0", ovf_w); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_break_and_packet();
    test_exact();
    test_back_to_back();
    test_reset_mid_packet();
    test_count_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
